// File: rtl/rv32_pkg.sv
// Shared RV32 decode types: write-back source, branch condition, format codes
// and the execute-control bundle carried from decode to execute.
package rv32_pkg;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_PC,
    WB_LSU,
    WB_CSR
  } wb_source_t;

  typedef enum logic [2:0] {
    BR_NOP,
    BR_EQ,
    BR_NE,
    BR_GT,
    BR_GE,
    BR_LT,
    BR_LE
  } br_condition_t;

  localparam logic [5:0] FMT_R = 6'b100000;
  localparam logic [5:0] FMT_I = 6'b010000;
  localparam logic [5:0] FMT_S = 6'b001000;
  localparam logic [5:0] FMT_B = 6'b001100;
  localparam logic [5:0] FMT_U = 6'b000010;
  localparam logic [5:0] FMT_J = 6'b000011;

  typedef struct packed {
    logic          rf_we;
    logic          op0_pc;
    logic          op1_imm;
    logic          alu_force_add;
    logic [3:0]    ram_req;
    logic          ram_wr;
    wb_source_t    wb;
    logic          csr_wr;
    logic          csr_rd;
    logic          csr_bit_op;
    logic          csr_bit_set_or_clr;
    logic          csr_use_imm;
    br_condition_t br_cond;
    logic          br_is_cond;
    logic          br_jmp;
    logic          error;
  } ctrl_t;

endpackage

// File: rtl/rv32_mod_ctrl_fifo.sv
// Generic synchronous FIFO (power-of-two DEPTH) with a synchronous clear that
// overrides push and pop; rdata shows the head entry whenever !empty.
module rv32_mod_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // The extra pointer bit separates full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments; combinational logic uses blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is reset because the head entry is visible on rdata straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/rv32_mod_decode_ctrl_stage.sv
// Control-decode stage: turns {format, func, qualifiers} into a ctrl_t bundle,
// buffers bundles with their tags, and counts accepted illegal instructions.
module rv32_mod_decode_ctrl_stage
  import rv32_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int TAG_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [5:0]           instruction_format,
  input  logic [5:0]           func,
  input  logic                 is_mem_or_io,
  input  logic                 is_system,
  input  logic                 rf_target_is_x0,
  input  logic                 rf_source_is_x0,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output ctrl_t                out_ctrl,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CTRL_W = $bits(ctrl_t);
  localparam int FIFO_W = TAG_W + CTRL_W;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  ctrl_t                dec_ctrl;
  logic                 push_fire, pop_fire;
  logic                 fifo_full, fifo_empty;
  logic [FIFO_W-1:0]    fifo_rdata;
  logic                 rst_done_q;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  function automatic ctrl_t decode_ctrl(
    input logic [5:0] fmt,
    input logic [5:0] fn,
    input logic       mem,
    input logic       sys,
    input logic       rd_x0,
    input logic       rs_x0
  );
    ctrl_t      c;
    logic [2:0] f3;
    f3              = fn[2:0];
    c               = '0;
    c.alu_force_add = 1'b1;
    c.wb            = WB_ALU;
    c.br_cond       = BR_NOP;
    case (fmt)
      FMT_R: begin
        c.rf_we         = 1'b1;
        c.alu_force_add = 1'b0;
      end
      FMT_I: begin
        if (mem) begin
          c.rf_we   = 1'b1;
          c.op1_imm = 1'b1;
          c.wb      = WB_LSU;
          c.ram_req = {1'b0, f3};
        end else if (fn[5]) begin
          c.rf_we   = 1'b1;
          c.op1_imm = 1'b1;
          c.br_jmp  = 1'b1;
          c.wb      = WB_PC;
        end else if (sys) begin
          // ECALL/EBREAK are trapped downstream via the error bit.
          if (f3 == 3'b000) begin
            c.error = 1'b1;
          end else begin
            c.rf_we       = !rd_x0;
            c.wb          = WB_CSR;
            c.csr_use_imm = f3[2];
            if (f3[1:0] == 2'b01) begin
              c.csr_wr = 1'b1;
              c.csr_rd = !rd_x0;
            end else if (f3[1]) begin
              c.csr_rd             = 1'b1;
              c.csr_wr             = !rs_x0;
              c.csr_bit_op         = 1'b1;
              c.csr_bit_set_or_clr = !f3[0];
            end
          end
        end else begin
          c.rf_we         = 1'b1;
          c.op1_imm       = 1'b1;
          c.alu_force_add = 1'b0;
        end
      end
      FMT_S: begin
        c.op1_imm = 1'b1;
        c.ram_req = fn[3:0];
        c.ram_wr  = 1'b1;
      end
      FMT_B: begin
        c.br_is_cond = 1'b1;
        c.br_cond    = br_condition_t'(f3);
        c.op0_pc     = 1'b1;
        c.op1_imm    = 1'b1;
      end
      FMT_U: begin
        c.rf_we   = 1'b1;
        c.op1_imm = 1'b1;
        c.op0_pc  = !fn[4];
      end
      FMT_J: begin
        c.rf_we   = 1'b1;
        c.op0_pc  = 1'b1;
        c.op1_imm = 1'b1;
        c.br_jmp  = 1'b1;
        c.wb      = WB_PC;
      end
      default: begin
        c       = '0;
        c.error = 1'b1;
      end
    endcase
    return c;
  endfunction

  always_comb begin
    dec_ctrl = decode_ctrl(instruction_format, func, is_mem_or_io, is_system,
                           rf_target_is_x0, rf_source_is_x0);
  end

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = rst_done_q && !fifo_full;
  assign out_valid = !fifo_empty;
  assign push_fire = in_valid && in_ready && !flush;
  assign pop_fire  = out_valid && out_ready && !flush;

  rv32_mod_ctrl_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push_fire),
    .wdata ({in_tag, dec_ctrl}),
    .pop   (pop_fire),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_tag  = fifo_rdata[FIFO_W-1 -: TAG_W];
  assign out_ctrl = ctrl_t'(fifo_rdata[CTRL_W-1:0]);

  always_comb begin
    err_count_d = err_count_q;
    if (push_fire && dec_ctrl.error && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_ONE;
    end
  end

  assign err_count = err_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      rst_done_q  <= 1'b1;
      err_count_q <= err_count_d;
    end
  end

endmodule
